// File: rtl/ram_arbiter.sv
`default_nettype none
// =====================================================================
// Module   : ram_arbiter
// Brief    : Round-robin sharing of one block RAM between two ports,
//            with a registered RAM bus and fixed-latency read return.
//            Optional macro ARB_DUAL_ISSUE_EN: a read and a write may be
//            granted together in one cycle.
// Revision : 1.0 - initial release
// =====================================================================
module ram_arbiter #(
    parameter int AW       = 9,
    parameter int DW       = 8,
    parameter int READ_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] ram_raddr,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    logic w_both;
    logic w_dual;
    logic w_gnt0;
    logic w_gnt1;
    logic w_wr0;
    logic w_wr1;
    logic w_rd0;
    logic w_rd1;
    logic w_ret;
    logic r_last;
    // Read tags; the p*_rvalid registers form the final stage.
    logic [READ_LAT-1:0] r_tag_v;
    logic [READ_LAT-1:0] r_tag_p;

    assign w_both = p0_req & p1_req;

`ifdef ARB_DUAL_ISSUE_EN
    assign w_dual = w_both & (p0_we ^ p1_we);
`else
    assign w_dual = 1'b0;
`endif

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst) begin
            if (w_dual) begin
                w_gnt0 = 1'b1;
                w_gnt1 = 1'b1;
            end else if (w_both) begin
                w_gnt0 = r_last;
                w_gnt1 = ~r_last;
            end else begin
                w_gnt0 = p0_req;
                w_gnt1 = p1_req;
            end
        end
    end

    assign p0_gnt = w_gnt0;
    assign p1_gnt = w_gnt1;
    assign w_wr0  = w_gnt0 & p0_we;
    assign w_wr1  = w_gnt1 & p1_we;
    assign w_rd0  = w_gnt0 & ~p0_we;
    assign w_rd1  = w_gnt1 & ~p1_we;
    assign w_ret  = r_tag_v[READ_LAT-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last    <= 1'b1;
            ram_we    <= 1'b0;
            ram_raddr <= '0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            r_tag_v   <= '0;
            r_tag_p   <= '0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            if (!w_dual) begin
                if (w_gnt0) begin
                    r_last <= 1'b0;
                end else if (w_gnt1) begin
                    r_last <= 1'b1;
                end
            end

            ram_we <= w_wr0 | w_wr1;
            if (w_wr0) begin
                ram_waddr <= p0_addr;
                ram_wdata <= p0_wdata;
            end else if (w_wr1) begin
                ram_waddr <= p1_addr;
                ram_wdata <= p1_wdata;
            end

            if (w_rd0) begin
                ram_raddr <= p0_addr;
            end else if (w_rd1) begin
                ram_raddr <= p1_addr;
            end

            r_tag_v[0] <= w_rd0 | w_rd1;
            r_tag_p[0] <= w_rd1;
            for (int i = 1; i < READ_LAT; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_p[i] <= r_tag_p[i-1];
            end

            p0_rvalid <= w_ret & ~r_tag_p[READ_LAT-1];
            p1_rvalid <= w_ret &  r_tag_p[READ_LAT-1];
            if (w_ret & ~r_tag_p[READ_LAT-1]) begin
                p0_rdata <= ram_rdata;
            end
            if (w_ret & r_tag_p[READ_LAT-1]) begin
                p1_rdata <= ram_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// =====================================================================
// Module   : tb_ram_arbiter
// Brief    : Two arbiters (READ_LAT 1 and 3) on shared stimulus, each with
//            its own RAM, checked against a transaction-level model.
// Revision : 1.0 - initial release
// =====================================================================
module tb_ram_arbiter;

    localparam int AW = 9;
    localparam int DW = 8;
`ifdef ARB_DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] wd; } op_t;
    typedef struct { int cyc; int port; int data; } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_next = 1'b0;
    logic p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;

    logic [1:0]    gnt0_w, gnt1_w, rv0_w, rv1_w, we_w;
    logic [DW-1:0] rd0_w [2];
    logic [DW-1:0] rd1_w [2];
    logic [DW-1:0] wd_w  [2];
    logic [DW-1:0] ramrd_w [2];
    logic [AW-1:0] ra_w  [2];
    logic [AW-1:0] wa_w  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(int a);
        if (a == 'h010) return 8'h3C;
        if (a == 'h020) return 8'h11;
        return 8'((a * 37 + 5) & 255);
    endfunction

    for (genvar i = 0; i < 2; i++) begin : g_dut
        localparam int LAT = (i == 0) ? 1 : 3;
        logic [DW-1:0] mem  [0:(1<<AW)-1];
        logic [DW-1:0] pipe [0:3];

        initial for (int a = 0; a < (1 << AW); a++) mem[a] <= init_val(a);

        // RAM: data for the address presented in cycle t is visible in cycle t+LAT-1
        always @(posedge clk) begin
            pipe[0] <= mem[ra_w[i]];
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
            if (we_w[i]) mem[wa_w[i]] <= wd_w[i];
        end
        assign ramrd_w[i] = (LAT == 1) ? mem[ra_w[i]] : pipe[LAT-2];

        ram_arbiter #(.AW(AW), .DW(DW), .READ_LAT(LAT)) u_dut (
            .clk(clk), .rst(rst),
            .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
            .p0_gnt(gnt0_w[i]), .p0_rvalid(rv0_w[i]), .p0_rdata(rd0_w[i]),
            .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
            .p1_gnt(gnt1_w[i]), .p1_rvalid(rv1_w[i]), .p1_rdata(rd1_w[i]),
            .ram_raddr(ra_w[i]), .ram_waddr(wa_w[i]), .ram_wdata(wd_w[i]),
            .ram_we(we_w[i]), .ram_rdata(ramrd_w[i])
        );
    end

    // ---------------- model state ----------------
    op_t q0[$];
    op_t q1[$];
    int cyc = 0;
    bit m_last = 1'b1;
    logic [DW-1:0] mmem [0:(1<<AW)-1];
    bit sv [2][16];
    bit sp [2][16];
    logic [DW-1:0] sd [2][16];
    bit erv0 [2];
    bit erv1 [2];
    logic [DW-1:0] erd0 [2];
    logic [DW-1:0] erd1 [2];
    bit ewe = 1'b0;
    logic [AW-1:0] ewa = '0, era = '0;
    logic [DW-1:0] ewd = '0;

    ev_t gl[$];
    ev_t rl_l1[$];
    ev_t rl_l3[$];
    ev_t wlog[$];
    int raddr_at[64];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_gnt(output bit g0, output bit g1);
        g0 = 1'b0;
        g1 = 1'b0;
        if (rst) begin
            if (p0_req && p1_req) begin
                if (DUAL && (p0_we != p1_we)) begin
                    g0 = 1'b1;
                    g1 = 1'b1;
                end else if (m_last) g0 = 1'b1;
                else g1 = 1'b1;
            end else begin
                g0 = p0_req;
                g1 = p1_req;
            end
        end
    endfunction

    // Transaction-level update at the end of cycle `cyc`.
    task automatic model_edge();
        bit g0, g1, gp, wep;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int idx;
        if (!rst) begin
            m_last = 1'b1; ewe = 1'b0; ewa = '0; ewd = '0; era = '0;
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 16; k++) sv[i][k] = 1'b0;
                erd0[i] = '0; erd1[i] = '0;
            end
        end else begin
            model_gnt(g0, g1);
            // reads see only writes granted in earlier cycles
            for (int p = 0; p < 2; p++) begin
                gp = (p == 1) ? g1 : g0;
                wep = (p == 1) ? p1_we : p0_we;
                a = (p == 1) ? p1_addr : p0_addr;
                if (gp && !wep) begin
                    era = a;
                    for (int i = 0; i < 2; i++) begin
                        idx = (cyc + 1 + ((i == 0) ? 1 : 3)) % 16;
                        sv[i][idx] = 1'b1; sp[i][idx] = (p == 1); sd[i][idx] = mmem[a];
                    end
                end
            end
            ewe = 1'b0;
            for (int p = 0; p < 2; p++) begin
                gp = (p == 1) ? g1 : g0;
                wep = (p == 1) ? p1_we : p0_we;
                a = (p == 1) ? p1_addr : p0_addr;
                d = (p == 1) ? p1_wdata : p0_wdata;
                if (gp && wep) begin
                    ewe = 1'b1; ewa = a; ewd = d; mmem[a] = d;
                end
            end
            if (!(g0 && g1)) begin
                if (g0) m_last = 1'b0;
                else if (g1) m_last = 1'b1;
            end
            if (g0) void'(q0.pop_front());
            if (g1) void'(q1.pop_front());
        end
        cyc++;
        for (int i = 0; i < 2; i++) begin
            idx = cyc % 16;
            erv0[i] = 1'b0; erv1[i] = 1'b0;
            if (sv[i][idx]) begin
                if (sp[i][idx]) begin erv1[i] = 1'b1; erd1[i] = sd[i][idx]; end
                else begin erv0[i] = 1'b1; erd0[i] = sd[i][idx]; end
                sv[i][idx] = 1'b0;
            end
        end
    endtask

    task automatic compare();
        bit eg0, eg1;
        model_gnt(eg0, eg1);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("L%0d p0_gnt", i), int'(gnt0_w[i]), int'(eg0));
            chk($sformatf("L%0d p1_gnt", i), int'(gnt1_w[i]), int'(eg1));
            chk($sformatf("L%0d p0_rvalid", i), int'(rv0_w[i]), int'(erv0[i]));
            chk($sformatf("L%0d p1_rvalid", i), int'(rv1_w[i]), int'(erv1[i]));
            chk($sformatf("L%0d p0_rdata", i), int'(rd0_w[i]), int'(erd0[i]));
            chk($sformatf("L%0d p1_rdata", i), int'(rd1_w[i]), int'(erd1[i]));
            chk($sformatf("L%0d ram_we", i), int'(we_w[i]), int'(ewe));
            chk($sformatf("L%0d ram_raddr", i), int'(ra_w[i]), int'(era));
            if (ewe) begin
                chk($sformatf("L%0d ram_waddr", i), int'(wa_w[i]), int'(ewa));
                chk($sformatf("L%0d ram_wdata", i), int'(wd_w[i]), int'(ewd));
            end
        end
        if (gnt0_w[0]) gl.push_back('{cyc, 0, 0});
        if (gnt1_w[0]) gl.push_back('{cyc, 1, 0});
        if (rv0_w[0]) rl_l1.push_back('{cyc, 0, int'(rd0_w[0])});
        if (rv1_w[0]) rl_l1.push_back('{cyc, 1, int'(rd1_w[0])});
        if (rv0_w[1]) rl_l3.push_back('{cyc, 0, int'(rd0_w[1])});
        if (rv1_w[1]) rl_l3.push_back('{cyc, 1, int'(rd1_w[1])});
        if (we_w[0]) wlog.push_back('{cyc, int'(wa_w[0]), int'(wd_w[0])});
        raddr_at[cyc % 64] = int'(ra_w[0]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        rst = rst_next;
        p0_req = (q0.size() > 0);
        if (q0.size() > 0) begin p0_we = q0[0].we; p0_addr = q0[0].addr; p0_wdata = q0[0].wd; end
        p1_req = (q1.size() > 0);
        if (q1.size() > 0) begin p1_we = q1[0].we; p1_addr = q1[0].addr; p1_wdata = q1[0].wd; end
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((q0.size() + q1.size()) != 0 && k < 300) begin step(); k++; end
        chk("wait_idle timeout", q0.size() + q1.size(), 0);
        run(6);
    endtask

    task automatic clear_logs();
        gl.delete(); rl_l1.delete(); rl_l3.delete(); wlog.delete();
    endtask

    task automatic do_reset();
        rst_next = 1'b0; run(2); rst_next = 1'b1; run(1); clear_logs();
    endtask

    function automatic op_t mk(bit we, int a, int d);
        op_t o;
        o.we = we; o.addr = AW'(a); o.wd = DW'(d);
        return o;
    endfunction

    initial begin
        int g, n, late;
        for (int a = 0; a < (1 << AW); a++) mmem[a] = init_val(a);

        // T1: read 0x010 held through reset, then single read
        q0.push_back(mk(0, 'h010, 0));
        run(3);
        rst_next = 1'b1;
        clear_logs();
        wait_idle();
        chk("t1 grants", gl.size(), 1);
        if (gl.size() > 0) begin
            g = gl[0].cyc;
            chk("t1 gnt port", gl[0].port, 0);
            chk("t1 raddr", raddr_at[(g + 1) % 64], 'h010);
            chk("t1 rv count L1", rl_l1.size(), 1);
            chk("t1 rv count L3", rl_l3.size(), 1);
            if (rl_l1.size() > 0) begin
                chk("t1 rv cyc L1", rl_l1[0].cyc, g + 2);
                chk("t1 rv port L1", rl_l1[0].port, 0);
                chk("t1 rdata L1", rl_l1[0].data, 'h3C);
            end
            if (rl_l3.size() > 0) begin
                chk("t1 rv cyc L3", rl_l3[0].cyc, g + 4);
                chk("t1 rdata L3", rl_l3[0].data, 'h3C);
            end
        end

        // T2: both ports read every cycle
        do_reset();
        for (int k = 0; k < 3; k++) begin
            q0.push_back(mk(0, 'h040 + k, 0));
            q1.push_back(mk(0, 'h080 + k, 0));
        end
        wait_idle();
        chk("t2 grants", gl.size(), 6);
        for (int k = 0; k < gl.size(); k++) begin
            chk($sformatf("t2 gnt%0d port", k), gl[k].port, k % 2);
            chk($sformatf("t2 gnt%0d cyc", k), gl[k].cyc - gl[0].cyc, k);
        end
        chk("t2 rv count", rl_l1.size(), 6);

        // T3: write then read of the same address on consecutive cycles
        clear_logs();
        q1.push_back(mk(1, 'h1FF, 'hA5));
        step();
        q0.push_back(mk(0, 'h1FF, 0));
        wait_idle();
        chk("t3 we pulses", wlog.size(), 1);
        if (wlog.size() > 0) begin
            chk("t3 waddr", wlog[0].port, 'h1FF);
            chk("t3 wdata", wlog[0].data, 'hA5);
        end
        chk("t3 grants", gl.size(), 2);
        if (gl.size() > 1) chk("t3 read follows write", gl[1].cyc - gl[0].cyc, 1);
        chk("t3 rv count", rl_l1.size(), 1);
        if (rl_l1.size() > 0) chk("t3 rdata", rl_l1[0].data, 'hA5);

        // T4: reset while two reads are in flight
        clear_logs();
        q0.push_back(mk(0, 'h005, 0));
        q1.push_back(mk(0, 'h006, 0));
        run(2);
        rst_next = 1'b0;
        step();
        g = cyc;
        rst_next = 1'b1;
        run(8);
        chk("t4 grants", gl.size(), 2);
        late = 0;
        foreach (rl_l1[k]) if (rl_l1[k].cyc > g) late++;
        foreach (rl_l3[k]) if (rl_l3[k].cyc > g) late++;
        chk("t4 rvalid after reset", late, 0);
        n = gl.size();
        q0.push_back(mk(0, 'h007, 0));
        q1.push_back(mk(0, 'h008, 0));
        wait_idle();
        if (gl.size() > n) chk("t4 first tie", gl[n].port, 0);

        // T5: read of p0 alongside write of p1
        do_reset();
        q0.push_back(mk(0, 'h020, 0));
        q1.push_back(mk(1, 'h021, 'h30));
        wait_idle();
        chk("t5 grants", gl.size(), 2);
        if (gl.size() > 1) begin
            g = gl[0].cyc;
            chk("t5 first port", gl[0].port, 0);
            chk("t5 second gap", gl[1].cyc - g, DUAL ? 0 : 1);
            chk("t5 raddr", raddr_at[(g + 1) % 64], 'h020);
            if (wlog.size() > 0) chk("t5 write cyc", wlog[0].cyc - g, DUAL ? 1 : 2);
        end
        if (rl_l1.size() > 0) chk("t5 rdata", rl_l1[0].data, 'h11);

        // T6: single p1 read, latency per instance
        clear_logs();
        q1.push_back(mk(0, 'h033, 0));
        wait_idle();
        if (gl.size() > 0 && rl_l1.size() > 0 && rl_l3.size() > 0) begin
            g = gl[0].cyc;
            chk("t6 gnt port", gl[0].port, 1);
            chk("t6 L1 latency", rl_l1[0].cyc - g, 2);
            chk("t6 L3 latency", rl_l3[0].cyc - g, 4);
            chk("t6 L3 port", rl_l3[0].port, 1);
        end else begin
            chk("t6 events seen", gl.size() * rl_l1.size() * rl_l3.size(), 1);
        end

        // Random traffic with occasional resets
        for (int k = 0; k < 700; k++) begin
            if (q0.size() < 2 && ($urandom % 3) != 0)
                q0.push_back(mk(1'($urandom % 2), (($urandom % 5) == 0) ? 'h1FF : int'($urandom % 16),
                                int'($urandom % 256)));
            if (q1.size() < 2 && ($urandom % 3) != 0)
                q1.push_back(mk(1'($urandom % 2), (($urandom % 5) == 0) ? 'h1FF : int'($urandom % 16),
                                int'($urandom % 256)));
            rst_next = (($urandom % 150) != 0);
            step();
        end
        rst_next = 1'b1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single block RAM between two requesters, each of which may read or write.
- Port 0 is the CPU core. Port 1 is the UART program loader / debug monitor.
- Arbitrates one RAM operation per cycle using round-robin and registers the RAM address, data and strobe signals.
- Returns read data to the owning port with a fixed, known latency and a per-port valid strobe.

Parameters:
- AW, 9, RAM address width.
- DW, 8, RAM data width.
- READ_LAT, 1, cycles from ram_raddr registered at the RAM input to ram_rdata valid. Legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- p0_req  in  1  port 0 request; held high until granted.
- p0_we  in  1  port 0 operation: 1 = write, 0 = read.
- p0_addr  in  AW  port 0 address.
- p0_wdata  in  DW  port 0 write data.
- p0_gnt  out  1  port 0 request accepted this cycle.
- p0_rvalid  out  1  port 0 read data valid, one-cycle pulse.
- p0_rdata  out  DW  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- ram_raddr  out  AW  RAM read address.
- ram_waddr  out  AW  RAM write address.
- ram_wdata  out  DW  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  DW  RAM read data.

Behaviour:
- Reset (rst=0 at clk edge):
  - p*_gnt=0, p*_rvalid=0, ram_we=0.
  - ram_raddr, ram_waddr, ram_wdata, p*_rdata = 0.
  - Read-tracking pipeline cleared.
  - Priority pointer last=1, so port 0 wins the first tie.
- Grant: combinational from req and last, forced to 0 while rst=0.
  - Only one requester high: it is granted.
  - Both high: the port != last is granted.
  - last updates to the granted port on every grant.
- Accept: a request is accepted in the cycle it sees gnt=1. A port must hold req, we, addr and wdata stable until gnt.
  - After gnt, the port may present a new request in the next cycle.
  - Back-to-back grants to the same port are allowed when the other port is idle.
- Issue: the accepted operation is registered onto the RAM bus in the next cycle.
  - Write: ram_waddr <= addr, ram_wdata <= wdata, ram_we <= 1 for exactly one cycle.
  - Read: ram_raddr <= addr, ram_we <= 0. ram_raddr holds its value when idle.
- Read return: a tag pipeline of depth 1+READ_LAT carries {valid, port}.
  - A read accepted at cycle N yields p<port>_rvalid=1 and p<port>_rdata=ram_rdata at cycle N+1+READ_LAT.
  - p*_rdata is registered and holds its value until the next rvalid for that port.
  - The non-owning port's rvalid stays 0.
- Ordering: operations reach the RAM in grant order.
  - A write granted at N followed by a read to the same address granted at N+1 returns the new data, provided the RAM is read-after-write coherent one cycle later. The arbiter does no forwarding.
- Writes produce no rvalid.
- Simultaneous read returns and new grants are independent. Up to 1+READ_LAT reads may be in flight.
- Reset mid-operation: in-flight reads are discarded and no rvalid is emitted afterwards. A write already registered on the RAM bus completes in the reset cycle only if ram_we was already 1.

Optional Feature:
- Macro ARB_DUAL_ISSUE_EN.
- Defined:
  - When both ports request and exactly one is a write, both are granted in the same cycle. The read goes to ram_raddr and the write to ram_waddr on the same issue cycle.
  - last is unchanged on a dual grant.
  - A read and write to the same address in the same cycle returns the RAM's old data; this is documented RAM behaviour.
  - Two reads or two writes still arbitrate round-robin.
- Undefined: strictly one grant per cycle, as described above.

Test Plan:
- Reset, then p0 read addr 0x010 while RAM[0x010]=0x3C, READ_LAT=1 -> p0_gnt same cycle, ram_raddr=0x010 next cycle, p0_rvalid=1 with p0_rdata=0x3C two cycles after accept, p1_rvalid=0.
- p0 and p1 both request reads every cycle for 6 cycles -> grants alternate p0,p1,p0,p1,p0,p1, starting with p0. Each rvalid lands on the correct port with the correct RAM data.
- p1 writes 0xA5 to 0x1FF, then p0 reads 0x1FF in the next cycle -> ram_we pulses once with ram_waddr=0x1FF and ram_wdata=0xA5; p0_rdata=0xA5.
- Issue 2 reads, assert rst=0 for one cycle while they are in flight -> no rvalid on either port after reset. The first post-reset tie goes to p0.
- With ARB_DUAL_ISSUE_EN: p0 reads 0x020 (=0x11) while p1 writes 0x30 to 0x021 -> both gnt in the same cycle, ram_we=1 and ram_raddr=0x020 in the same issue cycle, p0_rdata=0x11. Without the macro: p0 is granted first, p1 in the next cycle.
- READ_LAT=3: single p1 read -> p1_rvalid exactly 4 cycles after gnt.
